instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage that sits directly upstream of `instruction_cache`. It generates sequential program-counter requests on the cache request handshake and collects the in-order instruction responses into a small queue. It presents each instruction with its PC to decode through a valid/ready handshake. Branch and jump redirects flush the queue and silently discard any cache responses still in flight.

## Interface
Parameters:
- `ADDR_SIZE`, 32: PC / cache address width.
- `INST_SIZE`, 32: instruction width.
- `RESET_PC`, 0: first fetch address after reset. Bits [1:0] must be 0.
- `FIFO_DEPTH`, 4: instruction queue entries. Power of two, ≥ 2.

Ports:
- `i_aclk` in 1: system clock.
- `i_areset` in 1: reset, asynchronous, active-high.
- `o_req` out 1: fetch request to `instruction_cache.i_req`.
- `i_req_ready` in 1: cache accepts the request this cycle (`o_req_ready`).
- `o_addr` out ADDR_SIZE: fetch address to `instruction_cache.i_addr`.
- `i_instr_valid` in 1: one-cycle response strobe from the cache. No backpressure.
- `i_instruction` in INST_SIZE: response data.
- `i_redirect` in 1: flush and restart fetch.
- `i_redirect_pc` in ADDR_SIZE: new PC. Bits [1:0] are ignored and forced to 0.
- `o_valid` out 1: decode output valid.
- `i_ready` in 1: decode accepts the head entry.
- `o_instr` out INST_SIZE: head instruction.
- `o_pc` out ADDR_SIZE: PC of the head instruction.

## Operation
Registers:
- `fetch_pc`: next address to request.
- `rsp_pc`: PC of the next kept response.
- `outstanding`: accepted requests not yet answered, including stale ones. Width is clog2(FIFO_DEPTH+1).
- `drop_cnt`: stale responses still to discard.
- Queue of {instr, pc}, with `count`.

Request issue:
- `o_req = !i_redirect && (count + outstanding < FIFO_DEPTH)`.
- `o_addr = fetch_pc`.
- Accept is `o_req && i_req_ready`. On accept, `fetch_pc += 4` (modulo 2^ADDR_SIZE, wraps to 0) and `outstanding++`.
- While unaccepted, `o_req` and `o_addr` hold stable. The only exception is a redirect, which may withdraw the request. Credit cannot shrink while waiting, because a response moves one unit from `outstanding` to `count`.

Response handling:
- Every `i_instr_valid` decrements `outstanding`.
- If `drop_cnt > 0`, the response is discarded and `drop_cnt--`.
- Otherwise {i_instruction, rsp_pc} is pushed and `rsp_pc += 4`.
- A push into a full queue is impossible by construction. The RTL carries an assertion for it.

Decode side:
- `o_valid = (count != 0)`.
- Pop on `o_valid && i_ready`. Push and pop in the same cycle leave `count` unchanged.
- `o_instr` and `o_pc` read 0 whenever `o_valid = 0`.

Redirect (highest priority):
- The queue is emptied (`count = 0`) and the pop is ignored.
- `fetch_pc = rsp_pc = {i_redirect_pc[ADDR_SIZE-1:2], 2'b00}`.
- `drop_cnt = outstanding - i_instr_valid`. A response arriving in the redirect cycle is itself discarded.
- `outstanding` decrements normally.
- Back-to-back redirects: each recomputes `drop_cnt` from the current `outstanding`. The last one wins.

## Timing
Reset values:
- `o_req` = 0, `o_addr` = RESET_PC, `o_valid` = 0, `o_instr` = 0, `o_pc` = 0.
- `fetch_pc` = `rsp_pc` = RESET_PC; `outstanding`, `drop_cnt` and `count` = 0.
- Reset asserted mid-operation clears all state immediately. Responses that arrive afterwards are not dropped; the cache is reset on the same signal.

Latency and throughput:
- First `o_req = 1` occurs in the first cycle after `i_areset` deasserts.
- Response to decode: `i_instr_valid` in cycle N gives `o_valid` in cycle N+1 (registered queue).
- Issue rate: up to one request per cycle while credit remains.
- Redirect in cycle N: `o_req = 0` in N, and the new `o_addr` is presented in N+1. `o_valid` is 0 in N+1, unless a kept response pushed in N+1 appears in N+2.

## Test plan
- Reset release, cache always ready, 1-cycle responses, `i_ready = 1` → `o_addr` sequence 0x0, 0x4, 0x8…; decode sees `o_pc` 0x0, 0x4… with the matching data and no gaps after fill.
- `i_ready = 0` held, FIFO_DEPTH=4 → exactly 4 requests accepted, `o_req` stays 0 until the first pop, then exactly one new request.
- Two requests outstanding, redirect to 0x1002 with no response that cycle → `drop_cnt = 2`, next `o_addr` = 0x1000; both old responses discarded; first decode entry is `o_pc` 0x1000.
- Redirect coincident with a response and a decode pop → that response is discarded, the queue is empty next cycle, `drop_cnt = outstanding - 1`.
- `i_req_ready` toggled randomly with `o_req` pending → `o_addr` never changes before acceptance; no duplicate or skipped PCs at decode.
- Redirect to 0xFFFFFFFC → fetches 0xFFFFFFFC then 0x00000000 (wrap).

Source files
------------

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch
//  Purpose  : Sequential PC fetch into instruction_cache, in-order response
//             queue toward decode, redirect flush with stale-response drop.
//  Revision : 1.0
// ============================================================================
module instruction_fetch #(
    parameter int                    ADDR_SIZE  = 32,
    parameter int                    INST_SIZE  = 32,
    parameter logic [ADDR_SIZE-1:0]  RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                 i_aclk,
    input  logic                 i_areset,
    output logic                 o_req,
    input  logic                 i_req_ready,
    output logic [ADDR_SIZE-1:0] o_addr,
    input  logic                 i_instr_valid,
    input  logic [INST_SIZE-1:0] i_instruction,
    input  logic                 i_redirect,
    input  logic [ADDR_SIZE-1:0] i_redirect_pc,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [INST_SIZE-1:0] o_instr,
    output logic [ADDR_SIZE-1:0] o_pc
);

    localparam int                   c_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int                   c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_SIZE-1:0] c_PC_STEP = ADDR_SIZE'(4);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]   c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0]   c_FULL    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W:0]     c_CREDIT  = (c_CNT_W + 1)'(FIFO_DEPTH);

    logic [ADDR_SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_SIZE-1:0] rsp_pc_q, rsp_pc_d;
    logic [c_CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [c_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [c_CNT_W-1:0]   count_q, count_d;
    logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [INST_SIZE-1:0] instr_mem_q [FIFO_DEPTH];
    logic [ADDR_SIZE-1:0] pc_mem_q    [FIFO_DEPTH];

    logic [c_CNT_W:0]     w_credit_used;
    logic                 w_req;
    logic                 w_accept;
    logic                 w_drop;
    logic                 w_push;
    logic                 w_pop;
    logic [ADDR_SIZE-1:0] w_redirect_pc;
    logic                 w_unused_pc_lsbs;

    // Low redirect bits are discarded by the word alignment below.
    assign w_unused_pc_lsbs = ^i_redirect_pc[1:0];
    assign w_redirect_pc    = {i_redirect_pc[ADDR_SIZE-1:2], 2'b00};

    assign w_credit_used = {1'b0, count_q} + {1'b0, outstanding_q};
    // Reset gating keeps o_req low while reset is held, high right after release.
    assign w_req    = !i_areset && !i_redirect && (w_credit_used < c_CREDIT);
    assign w_accept = w_req && i_req_ready;
    assign w_drop   = (drop_cnt_q != '0);
    assign w_push   = i_instr_valid && !w_drop && !i_redirect;
    assign w_pop    = (count_q != '0) && i_ready && !i_redirect;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        outstanding_d = outstanding_q + (w_accept ? c_CNT_ONE : '0)
                                      - (i_instr_valid ? c_CNT_ONE : '0);
        if (i_redirect) begin
            fetch_pc_d = w_redirect_pc;
            rsp_pc_d   = w_redirect_pc;
            drop_cnt_d = outstanding_q - (i_instr_valid ? c_CNT_ONE : '0);
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (w_accept) begin
                fetch_pc_d = fetch_pc_q + c_PC_STEP;
            end
            if (i_instr_valid && w_drop) begin
                drop_cnt_d = drop_cnt_q - c_CNT_ONE;
            end
            if (w_push) begin
                rsp_pc_d = rsp_pc_q + c_PC_STEP;
                wr_ptr_d = wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_PTR_ONE;
            end
            count_d = count_q + (w_push ? c_CNT_ONE : '0) - (w_pop ? c_CNT_ONE : '0);
        end
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Storage needs no reset: count_q qualifies every read.
    always_ff @(posedge i_aclk) begin
        if (w_push) begin
            instr_mem_q[wr_ptr_q] <= i_instruction;
            pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
        end
    end

    assign o_req   = w_req;
    assign o_addr  = fetch_pc_q;
    assign o_valid = (count_q != '0);
    assign o_instr = o_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign o_pc    = o_valid ? pc_mem_q[rd_ptr_q]    : '0;

    a_no_overflow: assert property (@(posedge i_aclk) disable iff (i_areset)
        !(w_push && (count_q == c_FULL)));

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch
//  Purpose  : Directed self-checking bench for instruction_fetch with a
//             1-cycle in-order cache responder model.
//  Revision : 1.0
// ============================================================================
module tb_instruction_fetch;

    logic        clk;
    logic        i_areset;
    logic        o_req;
    logic        i_req_ready;
    logic [31:0] o_addr;
    logic        i_instr_valid;
    logic [31:0] i_instruction;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_instr;
    logic [31:0] o_pc;

    int          n_total;
    int          n_pass;
    int          n_acc;
    logic        resp_en;
    logic [31:0] pend[$];

    instruction_fetch #(
        .ADDR_SIZE  (32),
        .INST_SIZE  (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (4)
    ) u_dut (
        .i_aclk        (clk),
        .i_areset      (i_areset),
        .o_req         (o_req),
        .i_req_ready   (i_req_ready),
        .o_addr        (o_addr),
        .i_instr_valid (i_instr_valid),
        .i_instruction (i_instruction),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_instr       (o_instr),
        .o_pc          (o_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock: records an accepted request, then presents the oldest
    // pending response one cycle later when the responder is enabled.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        acc = o_req && i_req_ready;
        a   = o_addr;
        @(posedge clk);
        #1;
        i_redirect = 1'b0;
        if (acc) begin
            pend.push_back(a);
            n_acc++;
        end
        if (resp_en && pend.size() > 0) begin
            i_instr_valid = 1'b1;
            i_instruction = mem_word(pend.pop_front());
        end else begin
            i_instr_valid = 1'b0;
            i_instruction = '0;
        end
        #1;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        i_areset      = 1'b1;
        i_req_ready   = 1'b1;
        i_ready       = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        i_instr_valid = 1'b0;
        i_instruction = '0;
        resp_en       = 1'b1;
        pend.delete();
        #1;
        check("rst_req",   {31'b0, o_req},   32'h0);
        check("rst_addr",  o_addr,           32'h0);
        check("rst_valid", {31'b0, o_valid}, 32'h0);
        check("rst_instr", o_instr,          32'h0);
        check("rst_pc",    o_pc,             32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        i_areset = 1'b0;
        n_acc    = 0;
        #1;
    endtask

    initial begin
        logic        prev_hold;
        logic [31:0] prev_addr;
        logic [31:0] exp_pc;

        n_total = 0;
        n_pass  = 0;
        n_acc   = 0;
        i_areset      = 1'b1;
        i_req_ready   = 1'b1;
        i_ready       = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        i_instr_valid = 1'b0;
        i_instruction = '0;
        resp_en       = 1'b1;

        // Streaming fetch with decode always ready
        reset_dut();
        check("first_req",  {31'b0, o_req}, 32'h1);
        check("first_addr", o_addr,         32'h0);
        tick();
        check("c1_addr",  o_addr,           32'h4);
        check("c1_valid", {31'b0, o_valid}, 32'h0);
        tick();
        for (int k = 0; k < 6; k++) begin
            check("stream_valid", {31'b0, o_valid}, 32'h1);
            check("stream_pc",    o_pc,             32'(4 * k));
            check("stream_instr", o_instr,          mem_word(32'(4 * k)));
            check("stream_addr",  o_addr,           32'(4 * (k + 2)));
            tick();
        end

        // Decode stalled: queue credit limits to four requests
        reset_dut();
        i_ready = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("stall_nacc",  32'(n_acc),        32'd4);
        check("stall_req",   {31'b0, o_req},    32'h0);
        check("stall_valid", {31'b0, o_valid},  32'h1);
        check("stall_pc",    o_pc,              32'h0);
        check("stall_instr", o_instr,           mem_word(32'h0));
        i_ready = 1'b1;
        #1;
        check("stall_req_full", {31'b0, o_req}, 32'h0);
        tick();
        i_ready = 1'b0;
        #1;
        check("pop_req",  {31'b0, o_req}, 32'h1);
        check("pop_addr", o_addr,         32'h10);
        check("pop_pc",   o_pc,           32'h4);
        tick();
        check("refill_req0", {31'b0, o_req}, 32'h0);
        tick();
        check("refill_req1", {31'b0, o_req}, 32'h0);
        check("refill_nacc", 32'(n_acc),     32'd5);

        // Redirect with two requests outstanding and no response that cycle
        reset_dut();
        resp_en = 1'b0;
        tick();
        tick();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h1002;
        #1;
        check("rd1_req", {31'b0, o_req}, 32'h0);
        tick();
        check("rd1_addr",   o_addr,           32'h1000);
        check("rd1_valid0", {31'b0, o_valid}, 32'h0);
        resp_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rd1_drop_valid", {31'b0, o_valid}, 32'h0);
        end
        tick();
        check("rd1_valid", {31'b0, o_valid}, 32'h1);
        check("rd1_pc",    o_pc,             32'h1000);
        check("rd1_instr", o_instr,          mem_word(32'h1000));
        tick();
        check("rd1_pc2",   o_pc,             32'h1004);

        // Redirect coincident with a response and a decode pop
        reset_dut();
        i_ready = 1'b0;
        tick();
        resp_en = 1'b0;
        tick();
        tick();
        resp_en = 1'b1;
        tick();
        check("rd2_pre_valid", {31'b0, o_valid},       32'h1);
        check("rd2_pre_pc",    o_pc,                   32'h0);
        check("rd2_pre_rsp",   {31'b0, i_instr_valid}, 32'h1);
        i_ready       = 1'b1;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h3000;
        #1;
        check("rd2_req", {31'b0, o_req}, 32'h0);
        tick();
        check("rd2_flush_valid", {31'b0, o_valid}, 32'h0);
        check("rd2_addr",        o_addr,           32'h3000);
        tick();
        check("rd2_drop_valid0", {31'b0, o_valid}, 32'h0);
        tick();
        check("rd2_drop_valid1", {31'b0, o_valid}, 32'h0);
        tick();
        check("rd2_valid", {31'b0, o_valid}, 32'h1);
        check("rd2_pc",    o_pc,             32'h3000);
        check("rd2_instr", o_instr,          mem_word(32'h3000));

        // Random cache backpressure: stable request, gapless PC order
        reset_dut();
        exp_pc    = 32'h0;
        prev_hold = 1'b0;
        prev_addr = '0;
        for (int k = 0; k < 60; k++) begin
            i_req_ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_hold) begin
                check("bp_req_hold",  {31'b0, o_req}, 32'h1);
                check("bp_addr_hold", o_addr,         prev_addr);
            end
            if (o_valid) begin
                check("bp_pc",    o_pc,    exp_pc);
                check("bp_instr", o_instr, mem_word(exp_pc));
                exp_pc = exp_pc + 32'h4;
            end
            prev_hold = o_req && !i_req_ready;
            prev_addr = o_addr;
            tick();
        end
        i_req_ready = 1'b1;

        // Address wrap at the top of the address space
        reset_dut();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'hFFFF_FFFF;
        #1;
        check("wrap_req0", {31'b0, o_req}, 32'h0);
        tick();
        check("wrap_addr0", o_addr,         32'hFFFF_FFFC);
        check("wrap_req1",  {31'b0, o_req}, 32'h1);
        tick();
        check("wrap_addr1", o_addr, 32'h0000_0000);
        tick();
        check("wrap_pc0",    o_pc,    32'hFFFF_FFFC);
        check("wrap_instr0", o_instr, mem_word(32'hFFFF_FFFC));
        tick();
        check("wrap_pc1",    o_pc,    32'h0000_0000);
        check("wrap_instr1", o_instr, mem_word(32'h0000_0000));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
